// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch and decode stages.
package rv32i_pkg;

  // Canonical NOP (addi x0, x0, 0) and the EBREAK encoding.
  localparam logic [31:0] NOP_IW    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_IW = 32'h0010_0073;

  // Major opcodes (instruction bits [6:0]).
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Fetch stage states: BOOT primes the memory, SQUASH hides the wrong-path word.
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2,
    HALT   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/rv32i_pc_reg.sv
// Program counter register: reset value, word-aligned redirect load, hold, +4 step.
module rv32i_pc_reg #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        hold,
  output logic [31:0] pc
);

  // Redirect beats hold; the low two address bits are always cleared on load.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= PC_RESET;
    end else if (load) begin
      pc <= load_addr & ~32'd3;
    end else if (!hold) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/rv32i_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous imem,
// presents instruction/PC pairs to decode, handles redirects and EBREAK halt.
module rv32i_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_in,
  input  logic               jump_enable_in,
  input  logic [31:0]        jump_addr_in,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        iw_out,
  output logic [31:0]        pc_out,
  output logic               valid_out,
  output logic               halted_out
);

  fetch_state_t state, state_next;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d1;
  logic         redirect;
  logic         halt_take;
  logic         freeze;

  // A redirect is honoured in every state except HALT; EBREAK only counts when on-path.
  assign redirect  = jump_enable_in && (state != HALT);
  assign halt_take = (state == RUN) && (imem_rdata == EBREAK_IW);
  assign freeze    = (state == HALT) || stall_in || halt_take;

  rv32i_pc_reg #(
    .PC_RESET (PC_RESET)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (redirect),
    .load_addr (jump_addr_in),
    .hold      (freeze),
    .pc        (pc_q)
  );

  // Track the PC of the word currently on imem_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_d1 <= 32'd0;
    end else if (redirect || !freeze) begin
      pc_d1 <= pc_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection in priority order: redirect, halt, stall, EBREAK, advance.
  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = SQUASH;
    end else if (state == HALT) begin
      state_next = HALT;
    end else if (stall_in) begin
      state_next = state;
    end else if (halt_take) begin
      state_next = HALT;
    end else begin
      state_next = RUN;
    end
  end

  // Memory interface: a redirect must always launch the target read.
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign imem_en   = jump_enable_in | (~stall_in & (state != HALT));

  // Decode-facing outputs are a pure function of state; non-RUN slots show a NOP.
  assign iw_out     = (state == RUN) ? imem_rdata : NOP_IW;
  assign pc_out     = pc_d1;
  assign valid_out  = (state == RUN);
  assign halted_out = (state == HALT);

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Self-checking bench for rv32i_fetch_unit: directed literal checks plus a
// randomized run compared each cycle against a slot-based behavioural model.
module tb_rv32i_fetch_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_in = 1'b0;
  logic        jump_enable_in = 1'b0;
  logic [31:0] jump_addr_in = 32'd0;
  logic [9:0]  imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] iw_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        halted_out;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [31:0] rom      [0:1023];
  logic [31:0] rom_next [0:1023];

  // Behavioural model: next fetch address plus one "slot" (word shown to decode).
  logic        m_init = 1'b0;
  logic [31:0] m_fpc  = 32'd0;
  logic [31:0] m_spc  = 32'd0;
  logic        m_sv   = 1'b0;
  logic        m_halt = 1'b0;

  rv32i_fetch_unit #(
    .PC_RESET (32'h0000_0000),
    .IMEM_AW  (10)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_in       (stall_in),
    .jump_enable_in (jump_enable_in),
    .jump_addr_in   (jump_addr_in),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rdata     (imem_rdata),
    .iw_out         (iw_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out),
    .halted_out     (halted_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory with clock-enable hold.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom[imem_addr];
  end

  function automatic logic [31:0] addi(input int i);
    return {12'(i), 5'd1, 3'b000, 5'd1, 7'h13};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: the slot word is always rom[slot pc], so no memory register is modelled.
  always @(posedge clk) begin
    if (reset) begin
      m_init <= 1'b1;
      m_fpc  <= 32'd0;
      m_spc  <= 32'd0;
      m_sv   <= 1'b0;
      m_halt <= 1'b0;
    end else if (m_init) begin
      if (jump_enable_in && !m_halt) begin
        m_spc <= m_fpc;
        m_sv  <= 1'b0;
        m_fpc <= {jump_addr_in[31:2], 2'b00};
      end else if (m_halt || stall_in) begin
        // nothing moves
      end else if (m_sv && rom[m_spc[11:2]] == EBREAK) begin
        m_halt <= 1'b1;
      end else begin
        m_spc <= m_fpc;
        m_sv  <= 1'b1;
        m_fpc <= m_fpc + 32'd4;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init && !reset) begin
      logic ev;
      ev = m_sv && !m_halt;
      chk("m_valid",  {31'd0, valid_out},  {31'd0, ev});
      chk("m_iw",     iw_out,              ev ? rom[m_spc[11:2]] : NOP);
      chk("m_pc",     pc_out,              m_spc);
      chk("m_halted", {31'd0, halted_out}, {31'd0, m_halt});
      chk("m_en",     {31'd0, imem_en},    {31'd0, jump_enable_in | (!stall_in && !m_halt)});
      chk("m_addr",   {22'd0, imem_addr},  {22'd0, m_fpc[11:2]});
    end
  end

  // One clock cycle: apply inputs just after the edge, return at mid-cycle.
  task automatic cyc(input logic j, input logic [31:0] a, input logic s);
    @(posedge clk); #1;
    jump_enable_in = j;
    jump_addr_in   = a;
    stall_in       = s;
    @(negedge clk);
  endtask

  // Reset for two edges, load the staged ROM, return in the BOOT cycle.
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    jump_enable_in = 1'b0;
    stall_in = 1'b0;
    rom = rom_next;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic seq_rom();
    for (int i = 0; i < 1024; i++) rom_next[i] = addi(i);
  endtask

  initial begin
    logic        j, s;
    logic [31:0] a;

    // Reset and sequential run.
    seq_rom();
    do_reset();
    chk("boot_valid", {31'd0, valid_out}, 32'd0);
    chk("boot_iw", iw_out, NOP);
    chk("boot_pc", pc_out, 32'd0);
    chk("boot_halted", {31'd0, halted_out}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 32'd0, 1'b0);
      chk("seq_pc", pc_out, 32'(4 * k));
      chk("seq_iw", iw_out, addi(k));
      chk("seq_valid", {31'd0, valid_out}, 32'd1);
    end

    // Jump to 0x40 while pc_out=8.
    do_reset();
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b1, 32'h40, 1'b0);
    chk("jmp_pc_t", pc_out, 32'h8);
    cyc(1'b0, 32'd0, 1'b0);
    chk("jmp_sq_valid", {31'd0, valid_out}, 32'd0);
    chk("jmp_sq_iw", iw_out, NOP);
    cyc(1'b0, 32'd0, 1'b0);
    chk("jmp_tgt_pc", pc_out, 32'h40);
    chk("jmp_tgt_iw", iw_out, addi(16));
    cyc(1'b0, 32'd0, 1'b0);
    chk("jmp_next_pc", pc_out, 32'h44);

    // Stall for three cycles at pc_out=0x10.
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 32'd0, 1'b1);
      chk("stall_pc", pc_out, 32'h10);
      chk("stall_iw", iw_out, addi(4));
      chk("stall_en", {31'd0, imem_en}, 32'd0);
      chk("stall_addr", {22'd0, imem_addr}, 32'd5);
    end
    cyc(1'b0, 32'd0, 1'b0);
    chk("stall_rel_pc", pc_out, 32'h10);
    cyc(1'b0, 32'd0, 1'b0);
    chk("stall_resume_pc", pc_out, 32'h14);

    // EBREAK at 0x0C halts; jumps ignored; reset restarts.
    rom_next[3] = EBREAK;
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("ebk_pc", pc_out, 32'hC);
    chk("ebk_iw", iw_out, EBREAK);
    chk("ebk_valid", {31'd0, valid_out}, 32'd1);
    cyc(1'b0, 32'd0, 1'b0);
    chk("ebk_halted", {31'd0, halted_out}, 32'd1);
    chk("ebk_nop", iw_out, NOP);
    cyc(1'b1, 32'h40, 1'b0);
    chk("ebk_jmp_halted", {31'd0, halted_out}, 32'd1);
    cyc(1'b0, 32'd0, 1'b0);
    chk("ebk_after_jmp_valid", {31'd0, valid_out}, 32'd0);
    chk("ebk_after_jmp_pc", pc_out, 32'hC);
    rom_next[3] = addi(3);
    do_reset();
    chk("rst_halted", {31'd0, halted_out}, 32'd0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd1);

    // EBREAK at 0x24 presented in the cycle of a jump to 0x80: no halt.
    rom_next[9] = EBREAK;
    do_reset();
    for (int k = 0; k < 9; k++) cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b1, 32'h80, 1'b0);
    chk("ebj_pc", pc_out, 32'h24);
    cyc(1'b0, 32'd0, 1'b0);
    chk("ebj_sq_halted", {31'd0, halted_out}, 32'd0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("ebj_tgt_pc", pc_out, 32'h80);
    chk("ebj_tgt_valid", {31'd0, valid_out}, 32'd1);
    rom_next[9] = addi(9);

    // Jump together with stall, misaligned target 0x103.
    do_reset();
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b1, 32'h103, 1'b1);
    chk("js_en", {31'd0, imem_en}, 32'd1);
    cyc(1'b0, 32'd0, 1'b0);
    chk("js_sq_valid", {31'd0, valid_out}, 32'd0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("js_tgt_pc", pc_out, 32'h100);
    chk("js_tgt_iw", iw_out, addi(64));

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      if (c == 0 || $urandom_range(0, 99) == 0) begin
        for (int i = 0; i < 1024; i++)
          rom_next[i] = ($urandom_range(0, 63) == 0) ? EBREAK : $urandom;
        do_reset();
      end
      j = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else a = $urandom;
      cyc(j, a, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_fetch_unit.md
Name: rv32i_fetch_unit

Overview:
Instruction fetch stage of the 5-stage RV32I pipeline, sitting directly upstream of the decode stage.
- Owns the program counter and drives a synchronous-read instruction memory (one-cycle latency, clock-enable hold).
- Presents each instruction word with its PC to decode.
- Accepts taken-jump redirects from decode, squashing the wrong-path slot.
- Stops fetching permanently on EBREAK until reset.

Parameters:
PC_RESET, 32'h0000_0000, PC loaded on reset (word aligned)
IMEM_AW, 10, instruction memory word-address width (memory depth = 2**IMEM_AW words)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
stall_in  in  1  hold fetch; outputs and PC frozen
jump_enable_in  in  1  taken jump/branch from decode, single-cycle pulse
jump_addr_in  in  32  redirect target from decode
imem_addr  out  IMEM_AW  word address = pc_q[IMEM_AW+1:2]
imem_en  out  1  memory clock enable; memory output holds when low
imem_rdata  in  32  memory data for the address presented on the previous enabled cycle
iw_out  out  32  instruction word to decode
pc_out  out  32  PC of iw_out
valid_out  out  1  iw_out is a real, on-path instruction
halted_out  out  1  EBREAK retired from fetch; sticky until reset

Behaviour:
- State registers:
  - pc_q: address being fetched.
  - pc_d1: PC of the word on imem_rdata.
  - state in {BOOT, RUN, SQUASH, HALT}.
- Reset: pc_q=PC_RESET, pc_d1=0, state=BOOT.
  - Resulting outputs: iw_out=32'h13, pc_out=0, valid_out=0, halted_out=0.
  - Reset overrides all other inputs in any state, including mid-redirect and HALT.
- Outputs are combinational from state:
  - iw_out = (state==RUN) ? imem_rdata : 32'h13
  - pc_out = pc_d1
  - valid_out = (state==RUN)
  - halted_out = (state==HALT)
- imem_en = jump_enable_in | (~stall_in & state!=HALT).
- Per-cycle update (non-reset), in priority order:
  1. jump_enable_in && state!=HALT:
     - pc_q <= {jump_addr_in[31:2],2'b00}; low bits are forced to zero.
     - pc_d1 <= pc_q; state <= SQUASH.
     - stall_in is ignored this cycle.
  2. state==HALT: all registers hold. jump_enable_in and stall_in are ignored.
  3. stall_in: pc_q, pc_d1 and state hold. Outputs are stable for the whole stall.
  4. state==RUN && imem_rdata==32'h0010_0073 (EBREAK):
     - state <= HALT; pc_q and pc_d1 hold.
     - The EBREAK word itself is presented once with valid_out=1.
  5. Otherwise: pc_d1 <= pc_q; pc_q <= pc_q + 4 (32-bit modulo, 0xFFFF_FFFC wraps to 0); state <= RUN.
- Latency:
  - First valid instruction (PC_RESET) appears 2 cycles after reset deasserts: the BOOT cycle, then RUN.
  - After a jump pulse in cycle T: cycle T+1 outputs NOP (SQUASH); the target instruction appears with valid_out=1 in cycle T+2.
- Wrong path:
  - The word fetched in the cycle of the redirect is never presented.
  - An EBREAK on imem_rdata during BOOT or SQUASH, or in the same cycle as jump_enable_in, is not acted on.
- Back-to-back jumps (pulse in T and T+1): the second target wins; the state stays in SQUASH one more cycle.
- Misaligned jump_addr_in: bits [1:0] are silently cleared; no exception.
- imem_addr truncates pc_q; addresses beyond the memory depth alias.

Decomposition:
- Shared package rv32i_pkg holds:
  - NOP_IW = 32'h0000_0013
  - EBREAK_IW = 32'h0010_0073
  - opcode constants
  - the fetch state enum typedef (BOOT, RUN, SQUASH, HALT)
  - the decode stage also uses NOP_IW and the opcode constants from this package.
- One natural sub-module, rv32i_pc_reg: PC register with reset value, increment, redirect-load and hold inputs.
- The state machine and output mux stay in rv32i_fetch_unit.

Test Plan:
- Reset, then run 6 cycles against a ROM of sequential ADDIs → cycle 1 NOP/valid 0; cycles 2..6 pc_out 0,4,8,12,16 with matching words and valid_out=1.
- Jump pulse (addr 0x40) in the cycle pc_out=8 → next cycle NOP, valid_out=0; following cycle pc_out=0x40, then 0x44.
- stall_in high 3 cycles while pc_out=0x10 → iw_out, pc_out and imem_addr constant, imem_en=0; resumes with pc_out=0x14.
- EBREAK at 0x0C → pc_out=0x0C presented once with valid_out=1; then halted_out=1, NOP forever; jump pulses ignored; reset restarts at PC_RESET.
- EBREAK at 0x24 fetched in the cycle a jump to 0x80 arrives → no halt; pc_out=0x80 two cycles later.
- jump_enable_in and stall_in together, jump_addr_in=0x103 → redirect taken to 0x100; pc_out=0x100 with valid_out=1 in T+2 (stall low from T+1).
